outport_uart_tx: RTL
====================

OUTPORT_UART_TX -- requirements
Module: outport_uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16, gives clock cycles per serial bit; legal range is 2..65535.
REQ-002 Parameter FIFO_DEPTH, default 4, gives word FIFO entries; it SHALL be a power of 2, minimum 2.
REQ-003 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 Port wr_en, input, 1 bit: write strobe from the output-port register load enable.
REQ-006 Port wr_data, input, 32 bits: word written to the output port, sampled when wr_en=1.
REQ-007 Port tx, output, 1 bit: serial line, 8N1, idle high.
REQ-008 Port busy, output, 1 bit: high whenever the FSM is not in IDLE.
REQ-009 Port full, output, 1 bit: high when the FIFO holds FIFO_DEPTH words.
REQ-010 Port overflow, output, 1 bit: sticky flag marking a dropped write.

Function
REQ-011 The block SHALL push wr_data into the FIFO on each rising edge with wr_en=1 and full=0.
REQ-012 On wr_en=1 with full=1 and no pop in the same cycle, the block SHALL drop the write and set overflow; overflow clears only on reset.
REQ-013 On wr_en=1 with full=1 and a pop in the same cycle, the block SHALL accept the write, leave the count unchanged and leave overflow unchanged.
REQ-014 FSM states SHALL be IDLE, START, DATA and STOP.
REQ-015 IDLE with FIFO non-empty SHALL pop the head into a 32-bit shift register, set byte index=0 and go to START; tx goes low on that edge.
REQ-016 START SHALL drive tx=0 for CLKS_PER_BIT cycles, then go to DATA.
REQ-017 DATA SHALL send bits 7..0 of the current byte LSB first, each held CLKS_PER_BIT cycles, then go to STOP.
REQ-018 STOP SHALL drive tx=1 for CLKS_PER_BIT cycles.
- If byte index<3: increment the index, shift the word right 8 and go to START with no gap.
- If byte index=3: go to IDLE.
REQ-019 Byte order SHALL be wr_data[7:0], [15:8], [23:16], [31:24].
REQ-020 A word SHALL occupy exactly 40*CLKS_PER_BIT cycles from its first start-bit cycle to its last stop-bit cycle.
REQ-021 Back-to-back words SHALL be separated by exactly one extra idle-high cycle, which is the IDLE pop cycle.
REQ-022 A write into an empty FIFO with FSM in IDLE at edge n SHALL drive tx low after edge n+1.
REQ-023 A pop SHALL occur only in IDLE, so the FIFO never pops while a word is in flight.
REQ-024 tx, busy, full and overflow SHALL be driven directly from registers; no combinational path from inputs to outputs.
REQ-025 The bit-time counter SHALL count 0..CLKS_PER_BIT-1 and wrap with no off-by-one; the FIFO pointers SHALL wrap modulo FIFO_DEPTH.

Reset
REQ-026 On reset assertion, at any time including mid-frame, the block SHALL immediately force tx=1, busy=0, full=0 and overflow=0.
REQ-027 Reset SHALL also force FSM=IDLE, empty the FIFO and zero all counters; any in-flight word is lost.
REQ-028 Writes during reset SHALL be ignored.
REQ-029 After reset deassertion, the first wr_en edge SHALL be accepted normally.

Structure
REQ-030 A shared package SHALL hold the state enum (IDLE, START, DATA, STOP), BITS_PER_BYTE=8, BYTES_PER_WORD=4 and FRAME_BITS=10.
REQ-031 The FIFO SHALL be a separate sub-module, word_fifo, with push, pop, din, dout, full and empty ports, parameterised on width and depth.
REQ-032 The FSM, shift register and bit counter SHALL reside in outport_uart_tx.

Verification
All scenarios use CLKS_PER_BIT=4 and FIFO_DEPTH=4.
REQ-033 Write 0x44332211 once -> tx low after 2 edges; bytes 0x11, 0x22, 0x33, 0x44 decoded LSB-first with valid stop bits; busy high for exactly 160 cycles.
REQ-034 Write 0xA5A5A5A5 then 0x0000FFFF on consecutive cycles -> 321 cycles from first start bit to end of second word, including one idle cycle between words.
REQ-035 Five writes on consecutive cycles starting in IDLE -> five words transmitted in order, overflow stays 0, since the first pop frees a slot.
REQ-036 Six writes while busy with the FIFO already full -> full=1, overflow=1 after the first dropped write, and only the FIFO contents are transmitted.
REQ-037 Assert reset mid-DATA of byte 2 -> tx=1, busy=0 and FIFO empty immediately; a subsequent write of 0x000000FF transmits correctly.
REQ-038 Write to a full FIFO on the same cycle the FSM pops -> write accepted, full stays 1, overflow stays 0.

Source files
------------

// File: rtl/outport_uart_tx_pkg.sv
// rtl/outport_uart_tx_pkg.sv - shared types and framing constants for the output-port UART
package outport_uart_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam int BITS_PER_BYTE  = 8;
  localparam int BYTES_PER_WORD = 4;
  localparam int FRAME_BITS     = 10;

endpackage

// File: rtl/outport_uart_tx_word_fifo.sv
// rtl/outport_uart_tx_word_fifo.sv - word FIFO with registered full/empty flags
module word_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             do_push, do_pop;

  // A push into a full FIFO is still taken when the same edge pops a slot free.
  assign do_pop  = pop && !empty_q;
  assign do_push = push && (!full_q || do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    full_d  = (count_d == CW'(DEPTH));
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  assign dout  = mem_q[rd_ptr_q];
  assign full  = full_q;
  assign empty = empty_q;

endmodule

// File: rtl/outport_uart_tx.sv
// rtl/outport_uart_tx.sv - output-port word FIFO feeding an 8N1 serial transmitter
module outport_uart_tx
  import outport_uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_en,
  input  logic [31:0] wr_data,
  output logic        tx,
  output logic        busy,
  output logic        full,
  output logic        overflow
);

  localparam logic [15:0] CNT_MAX   = 16'(CLKS_PER_BIT - 1);
  localparam logic [2:0]  LAST_BIT  = 3'(BITS_PER_BYTE - 1);
  localparam logic [1:0]  LAST_BYTE = 2'(BYTES_PER_WORD - 1);

  tx_state_t   state_q, state_d;
  logic [15:0] bit_cnt_q, bit_cnt_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [1:0]  byte_idx_q, byte_idx_d;
  logic [31:0] shift_q, shift_d;
  logic        tx_q, tx_d;
  logic        busy_q, busy_d;
  logic        overflow_q, overflow_d;

  logic        fifo_pop;
  logic        fifo_full;
  logic        fifo_empty;
  logic [31:0] fifo_dout;
  logic        bit_end;
  logic [7:0]  cur_byte;
  logic [2:0]  next_bit;

  word_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (wr_en),
    .pop   (fifo_pop),
    .din   (wr_data),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign bit_end  = (bit_cnt_q == CNT_MAX);
  assign cur_byte = shift_q[7:0];
  assign next_bit = bit_idx_q + 3'd1;

  // tx_d always holds the level for the cycle after the edge, so the line is a pure flop.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    bit_idx_d  = bit_idx_q;
    byte_idx_d = byte_idx_q;
    shift_d    = shift_q;
    tx_d       = tx_q;
    fifo_pop   = 1'b0;
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          shift_d    = fifo_dout;
          byte_idx_d = 2'd0;
          bit_cnt_d  = 16'd0;
          tx_d       = 1'b0;
          state_d    = START;
        end
      end
      START: begin
        if (bit_end) begin
          bit_cnt_d = 16'd0;
          bit_idx_d = 3'd0;
          tx_d      = cur_byte[0];
          state_d   = DATA;
        end else begin
          bit_cnt_d = bit_cnt_q + 16'd1;
        end
      end
      DATA: begin
        if (bit_end) begin
          bit_cnt_d = 16'd0;
          if (bit_idx_q == LAST_BIT) begin
            tx_d    = 1'b1;
            state_d = STOP;
          end else begin
            bit_idx_d = next_bit;
            tx_d      = cur_byte[next_bit];
          end
        end else begin
          bit_cnt_d = bit_cnt_q + 16'd1;
        end
      end
      STOP: begin
        if (bit_end) begin
          bit_cnt_d = 16'd0;
          if (byte_idx_q == LAST_BYTE) begin
            tx_d    = 1'b1;
            state_d = IDLE;
          end else begin
            byte_idx_d = byte_idx_q + 2'd1;
            shift_d    = {8'h00, shift_q[31:8]};
            tx_d       = 1'b0;
            state_d    = START;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + 16'd1;
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = IDLE;
      end
    endcase
    busy_d     = (state_d != IDLE);
    overflow_d = overflow_q | (wr_en & fifo_full & ~fifo_pop);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      bit_cnt_q  <= 16'd0;
      bit_idx_q  <= 3'd0;
      byte_idx_q <= 2'd0;
      shift_q    <= 32'd0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      bit_idx_q  <= bit_idx_d;
      byte_idx_q <= byte_idx_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      overflow_q <= overflow_d;
    end
  end

  assign tx       = tx_q;
  assign busy     = busy_q;
  assign full     = fifo_full;
  assign overflow = overflow_q;

endmodule
